fetch_sequencer: RTL and testbench

Front-end controller that sequences instruction-fetch requests into the ICache and meters them against free space in the dual-entry-per-push instruction buffer. It owns the fetch PC and tracks buffer occupancy from push and issue events, so requests are launched only when the response is guaranteed a slot. On a pipeline flush it redirects the PC and discards responses that are still in flight. It sits between the PC/redirect logic, the ICache request port and the instruction buffer's push and issue interface.

---
 rtl/fetch_sequencer_pkg.sv | 24 ++
 rtl/fetch_sequencer_if.sv | 25 ++
 rtl/ibuf_credit_counter.sv | 77 +++++++
 rtl/fetch_sequencer.sv | 91 +++++++++
 tb/tb_fetch_sequencer.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared front-end definitions: buffer depth, reset PC, issue-mode encodings,
// fetch FSM states and the buffer-room check used to meter fetch launches.
package fetch_sequencer_pkg;

    localparam int          IBUF_DEPTH       = 16;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'hBFC0_0000;

    typedef enum logic {
        SingleIssue = 1'b0,
        DualIssue   = 1'b1
    } issue_mode_e;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } state_e;

    // True when one more pair request still has a guaranteed buffer slot.
    function automatic logic launch_room(int occ, int outs, int depth, int max_out);
        return (outs < max_out) && (occ + 2 * (outs + 1) <= depth);
    endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// ICache request port plus instruction-buffer push/issue port of the fetch sequencer.
interface fetch_sequencer_if #(
    parameter int DEPTH = fetch_sequencer_pkg::IBUF_DEPTH
);
    logic                     icache_req_o;
    logic [31:0]              icache_addr_o;
    logic                     icache_addr_ok_i;
    logic                     icache_data_ok_i;
    logic                     push_o;
    logic [31:0]              push_addr1_o;
    logic [31:0]              push_addr2_o;
    logic                     issue_i;
    logic                     issue_mode_i;
    logic [$clog2(DEPTH):0]   occupancy_o;

    modport master (
        output icache_req_o, icache_addr_o, push_o, push_addr1_o, push_addr2_o, occupancy_o,
        input  icache_addr_ok_i, icache_data_ok_i, issue_i, issue_mode_i
    );

    modport slave (
        input  icache_req_o, icache_addr_o, push_o, push_addr1_o, push_addr2_o, occupancy_o,
        output icache_addr_ok_i, icache_data_ok_i, issue_i, issue_mode_i
    );
endinterface

// File: rtl/ibuf_credit_counter.sv
// Occupancy / outstanding / discard bookkeeping for the instruction buffer,
// producing the launch permission for the fetch FSM.
module ibuf_credit_counter
    import fetch_sequencer_pkg::*;
#(
    parameter int DEPTH   = IBUF_DEPTH,
    parameter int MAX_OUT = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush_i,
    input  logic                   stall_i,
    input  logic                   accept_i,
    input  logic                   data_ok_i,
    input  logic                   issue_i,
    input  logic                   issue_mode_i,
    output logic                   push_o,
    output logic                   launch_ok_o,
    output logic                   launch_next_o,
    output logic [$clog2(DEPTH):0] occupancy_o
);
    localparam int OCC_W = $clog2(DEPTH) + 1;
    localparam int CNT_W = $clog2(MAX_OUT + 2) + 1;

    logic [OCC_W-1:0] occ_q, occ_d;
    logic [CNT_W-1:0] outs_q, outs_d;
    logic [CNT_W-1:0] disc_q, disc_d;
    int               occ_sum, outs_sum, disc_sum, issue_amt;
    logic             rsp_underflow, issue_underflow;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        push_o    = data_ok_i && (disc_q == '0) && !flush_i;
        issue_amt = issue_i ? ((issue_mode_i == DualIssue) ? 2 : 1) : 0;

        outs_sum = int'(outs_q) + (accept_i ? 1 : 0) - (data_ok_i ? 1 : 0);
        outs_d   = (outs_sum < 0) ? '0 : CNT_W'(outs_sum);

        occ_sum  = int'(occ_q) + (push_o ? 2 : 0) - issue_amt;
        occ_d    = (occ_sum < 0) ? '0 : OCC_W'(occ_sum);

        disc_sum = int'(disc_q) - ((data_ok_i && disc_q != '0) ? 1 : 0);
        if (flush_i) begin
            // Everything still in flight at the flush, including a request accepted
            // this very cycle, becomes stale; a response consumed now is not counted.
            occ_d    = '0;
            disc_sum = int'(outs_q) + (accept_i ? 1 : 0)
                     - ((data_ok_i && disc_q == '0) ? 1 : 0);
        end
        disc_d = (disc_sum < 0) ? '0 : CNT_W'(disc_sum);

        launch_ok_o   = !stall_i && launch_room(int'(occ_q), int'(outs_q), DEPTH, MAX_OUT);
        launch_next_o = !stall_i && launch_room(int'(occ_d), int'(outs_d), DEPTH, MAX_OUT);

        rsp_underflow   = data_ok_i && (outs_q == '0);
        issue_underflow = !flush_i && (occ_sum < 0);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ_q  <= '0;
            outs_q <= '0;
            disc_q <= '0;
        end else begin
            occ_q  <= occ_d;
            outs_q <= outs_d;
            disc_q <= disc_d;
        end
    end

    assign occupancy_o = occ_q;

    a_no_rsp_underflow: assert property (@(posedge clk) disable iff (!rst) !rsp_underflow);
    a_no_issue_underflow: assert property (@(posedge clk) disable iff (!rst) !issue_underflow);

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch request sequencer: owns the fetch and response PCs and runs the
// IDLE/REQ/WAIT request FSM, metered by the buffer credit counter.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int          DEPTH    = IBUF_DEPTH,
    parameter int          MAX_OUT  = 2,
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush_i,
    input  logic [31:0]        flush_pc_i,
    input  logic               stall_i,
    fetch_sequencer_if.master  bus
);
    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] rsp_pc_q, rsp_pc_d;
    logic [31:0] flush_pc;
    logic        req, accept, push, launch_ok, launch_next;

    assign flush_pc = flush_pc_i & ~32'h7;
    assign accept   = req && bus.icache_addr_ok_i;

    ibuf_credit_counter #(
        .DEPTH   (DEPTH),
        .MAX_OUT (MAX_OUT)
    ) u_credit (
        .clk           (clk),
        .rst           (rst),
        .flush_i       (flush_i),
        .stall_i       (stall_i),
        .accept_i      (accept),
        .data_ok_i     (bus.icache_data_ok_i),
        .issue_i       (bus.issue_i),
        .issue_mode_i  (bus.issue_mode_i),
        .push_o        (push),
        .launch_ok_o   (launch_ok),
        .launch_next_o (launch_next),
        .occupancy_o   (bus.occupancy_o)
    );

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        rsp_pc_d = rsp_pc_q;
        req      = 1'b0;

        unique case (state_q)
            IDLE: state_d = launch_ok ? REQ : WAIT;
            REQ: begin
                // The request stays up until accepted, regardless of stall_i.
                req = 1'b1;
                if (bus.icache_addr_ok_i) begin
                    pc_d    = pc_q + 32'd8;
                    state_d = launch_next ? REQ : WAIT;
                end
            end
            WAIT: if (launch_ok) state_d = REQ;
            default: state_d = IDLE;
        endcase

        if (push) rsp_pc_d = rsp_pc_q + 32'd8;

        if (flush_i) begin
            pc_d     = flush_pc;
            rsp_pc_d = flush_pc;
            state_d  = REQ;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            rsp_pc_q <= RESET_PC;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            rsp_pc_q <= rsp_pc_d;
        end
    end

    assign bus.icache_req_o  = req;
    assign bus.icache_addr_o = pc_q;
    assign bus.push_o        = push && rst;
    assign bus.push_addr1_o  = rsp_pc_q;
    assign bus.push_addr2_o  = rsp_pc_q + 32'd4;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: per-cycle vector table plus hand-written
// multi-cycle sequences (buffer fill, dual issue refill, held request, occupancy, reset).
module tb_fetch_sequencer;
    import fetch_sequencer_pkg::*;

    localparam int          DEPTH   = 16;
    localparam int          MAX_OUT = 2;
    localparam logic [31:0] R       = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush;
    logic [31:0] fpc;
    logic        stall;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_sequencer_if #(.DEPTH(DEPTH)) bus ();

    fetch_sequencer #(
        .DEPTH    (DEPTH),
        .MAX_OUT  (MAX_OUT),
        .RESET_PC (R)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (flush),
        .flush_pc_i (fpc),
        .stall_i    (stall),
        .bus        (bus.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rst_before;
        bit          fl;
        logic [31:0] fp;
        bit          st, ao, dk, is, md;
        bit          e_req;
        logic [31:0] e_addr;
        bit          e_push;
        logic [31:0] e_a1;
        int          e_occ;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t v(bit r, bit fl, logic [31:0] fp, bit st, bit ao, bit dk,
                               bit is, bit md, bit er, logic [31:0] ea, bit ep,
                               logic [31:0] e1, int eo);
        vec_t x;
        x.rst_before = r;  x.fl = fl;  x.fp = fp;  x.st = st;  x.ao = ao;  x.dk = dk;
        x.is = is;  x.md = md;  x.e_req = er;  x.e_addr = ea;  x.e_push = ep;
        x.e_a1 = e1;  x.e_occ = eo;
        return x;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_all(string tag, bit er, logic [31:0] ea, bit ep,
                             logic [31:0] e1, int eo);
        check({tag, " req"},   32'(bus.icache_req_o), 32'(er));
        check({tag, " addr"},  bus.icache_addr_o, ea);
        check({tag, " push"},  32'(bus.push_o), 32'(ep));
        check({tag, " addr1"}, bus.push_addr1_o, e1);
        check({tag, " addr2"}, bus.push_addr2_o, e1 + 32'd4);
        check({tag, " occ"},   32'(bus.occupancy_o), eo);
    endtask

    task automatic drive(bit fl, logic [31:0] fp, bit st, bit ao, bit dk, bit is, bit md);
        flush = fl;  fpc = fp;  stall = st;
        bus.icache_addr_ok_i = ao;
        bus.icache_data_ok_i = dk;
        bus.issue_i          = is;
        bus.issue_mode_i     = md;
    endtask

    // One clock cycle: inputs change just after the edge, outputs sampled on the falling edge.
    task automatic cyc(bit fl, logic [31:0] fp, bit st, bit ao, bit dk, bit is, bit md);
        @(posedge clk);
        #1;
        drive(fl, fp, st, ao, dk, is, md);
        @(negedge clk);
    endtask

    // Leaves the design in its IDLE cycle, just after reset release.
    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // Always-ready ICache returning each pair one cycle after acceptance; no issue.
    task automatic run_fill(input int n_cyc, inout logic [31:0] exp_pc, output int pushes);
        logic [31:0] q[$];
        logic [31:0] e;
        pushes = 0;
        for (int c = 0; c < n_cyc; c++) begin
            cyc(0, 0, 0, 1, q.size() > 0, 0, 0);
            if (bus.icache_data_ok_i) begin
                e = q.pop_front();
                check("fill push", 32'(bus.push_o), 32'd1);
                check("fill addr1", bus.push_addr1_o, e);
                check("fill addr2", bus.push_addr2_o, e + 32'd4);
                pushes++;
            end
            if (bus.icache_req_o) begin
                check("fill req addr", bus.icache_addr_o, exp_pc);
                q.push_back(exp_pc);
                exp_pc = exp_pc + 32'd8;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] exp_pc;
        int          pushes;

        // Reset values, with response and issue activity held high during reset.
        drive(0, 0, 0, 1, 1, 1, 1);
        #12;
        check_all("in reset", 0, R, 0, R, 0);
        do_reset();
        check_all("idle", 0, R, 0, R, 0);

        // Table A: two accepts, flush to 0x8000_0104, stale drops, new-PC push, single issue.
        vt.push_back(v(1, 0, 0, 0, 1, 0, 0, 0,  1, R,              0, R,              0));
        vt.push_back(v(0, 0, 0, 0, 1, 0, 0, 0,  1, R + 32'd8,      0, R,              0));
        vt.push_back(v(0, 1, 32'h8000_0104, 0, 0, 0, 0, 0,  0, R + 32'd16, 0, R,     0));
        vt.push_back(v(0, 0, 0, 0, 0, 1, 0, 0,  1, 32'h8000_0100,  0, 32'h8000_0100,  0));
        vt.push_back(v(0, 0, 0, 0, 1, 1, 0, 0,  1, 32'h8000_0100,  0, 32'h8000_0100,  0));
        vt.push_back(v(0, 0, 0, 0, 0, 1, 0, 0,  1, 32'h8000_0108,  1, 32'h8000_0100,  0));
        vt.push_back(v(0, 0, 0, 0, 0, 0, 1, 0,  1, 32'h8000_0108,  0, 32'h8000_0108,  2));
        vt.push_back(v(0, 0, 0, 0, 1, 0, 0, 0,  1, 32'h8000_0108,  0, 32'h8000_0108,  1));
        vt.push_back(v(0, 0, 0, 0, 0, 0, 0, 0,  1, 32'h8000_0110,  0, 32'h8000_0108,  1));
        // Table B: flush coinciding with addr_ok and data_ok.
        vt.push_back(v(1, 0, 0, 0, 1, 0, 0, 0,  1, R,              0, R,              0));
        vt.push_back(v(0, 1, 32'h0000_123C, 0, 1, 1, 0, 0,  1, R + 32'd8, 0, R,       0));
        vt.push_back(v(0, 0, 0, 0, 0, 1, 0, 0,  1, 32'h0000_1238,  0, 32'h0000_1238,  0));
        vt.push_back(v(0, 0, 0, 0, 1, 0, 0, 0,  1, 32'h0000_1238,  0, 32'h0000_1238,  0));
        vt.push_back(v(0, 0, 0, 0, 0, 1, 0, 0,  1, 32'h0000_1240,  1, 32'h0000_1238,  0));
        vt.push_back(v(0, 0, 0, 0, 0, 0, 0, 0,  1, 32'h0000_1240,  0, 32'h0000_1240,  2));

        for (int i = 0; i < vt.size(); i++) begin
            if (vt[i].rst_before) do_reset();
            cyc(vt[i].fl, vt[i].fp, vt[i].st, vt[i].ao, vt[i].dk, vt[i].is, vt[i].md);
            check_all($sformatf("vec%0d", i), vt[i].e_req, vt[i].e_addr, vt[i].e_push,
                      vt[i].e_a1, vt[i].e_occ);
        end

        // Fill from reset: exactly DEPTH/2 pushes, then the request line stays low.
        do_reset();
        exp_pc = R;
        run_fill(30, exp_pc, pushes);
        check("fill push count", pushes, DEPTH / 2);
        check("fill req low", 32'(bus.icache_req_o), 0);
        check("fill occ", 32'(bus.occupancy_o), DEPTH);

        // One dual issue from full: 16 -> 14, one refill request, back to 16.
        cyc(0, 0, 0, 0, 0, 1, 1);
        check("dual issue occ before", 32'(bus.occupancy_o), 16);
        cyc(0, 0, 0, 0, 0, 0, 0);
        check("dual issue occ after", 32'(bus.occupancy_o), 14);
        check("dual issue req wait", 32'(bus.icache_req_o), 0);
        run_fill(10, exp_pc, pushes);
        check("refill push count", pushes, 1);
        check("refill occ", 32'(bus.occupancy_o), 16);
        check("refill req low", 32'(bus.icache_req_o), 0);

        // Acceptance delayed 5 cycles while stall toggles: request and address hold.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            cyc(0, 0, k % 2 == 0, 0, 0, 0, 0);
            check($sformatf("held req c%0d", k), 32'(bus.icache_req_o), 1);
            check($sformatf("held addr c%0d", k), bus.icache_addr_o, R);
        end
        cyc(0, 0, 0, 1, 0, 0, 0);
        check("held accept req", 32'(bus.icache_req_o), 1);
        check("held accept addr", bus.icache_addr_o, R);
        cyc(0, 0, 0, 0, 0, 0, 0);
        check("after accept addr", bus.icache_addr_o, R + 32'd8);

        // Build occupancy 6, then single issue together with a push: 6 -> 7.
        do_reset();
        cyc(0, 0, 0, 1, 0, 0, 0);
        check_all("occ s0", 1, R,              0, R,              0);
        cyc(0, 0, 0, 1, 1, 0, 0);
        check_all("occ s1", 1, R + 32'd8,      1, R,              0);
        cyc(0, 0, 0, 1, 1, 0, 0);
        check_all("occ s2", 1, R + 32'd16,     1, R + 32'd8,      2);
        cyc(0, 0, 0, 1, 1, 0, 0);
        check_all("occ s3", 1, R + 32'd24,     1, R + 32'd16,     4);
        cyc(0, 0, 0, 0, 1, 1, 0);
        check_all("occ s4", 1, R + 32'd32,     1, R + 32'd24,     6);
        cyc(0, 0, 0, 0, 0, 0, 0);
        check_all("occ s5", 1, R + 32'd32,     0, R + 32'd32,     7);

        // Mid-stream reset: outputs return to reset values without waiting for a clock.
        #1;
        rst = 1'b0;
        bus.icache_data_ok_i = 1'b1;
        #1;
        check_all("mid reset", 0, R, 0, R, 0);
        do_reset();
        check_all("post reset idle", 0, R, 0, R, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
